// File: rtl/barrel_shifter_pkg.sv
// Shared constants for the barrel rotator slice.
package barrel_shifter_pkg;

    localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/barrel_shifter_rot_stage.sv
// One rotator stage: rotates left by the constant AMT when sel is high, else passes through.
module rot_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT   = 1
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] rotated;

    // Low bits move up by AMT; the top AMT bits wrap around to the bottom.
    assign rotated = {din[WIDTH-AMT-1:0], din[WIDTH-1:WIDTH-AMT]};
    assign dout    = sel ? rotated : din;

endmodule

// File: rtl/barrel_shifter.sv
// Logarithmic left rotator: SHW cascaded mux stages followed by a single output register.
module barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SHW-1:0]   k,
    input  logic [WIDTH-1:0] A_i,
    output logic [WIDTH-1:0] Y_o
);

    // chain[s] is the input to stage s; chain[SHW] is the fully rotated word.
    logic [SHW:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]        y_q;

    assign chain[0] = A_i;

    for (genvar s = 0; s < SHW; s++) begin : g_stage
        rot_stage #(
            .WIDTH (WIDTH),
            .AMT   (2 ** s)
        ) u_rot_stage (
            .sel  (k[s]),
            .din  (chain[s]),
            .dout (chain[s+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= chain[SHW];
        end
    end

    assign Y_o = y_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: directed cases plus random traffic vs. a rotate model.
module tb_barrel_shifter;

    localparam int unsigned W  = 8;
    localparam int unsigned SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [SW-1:0] k   = '0;
    logic [W-1:0]  a   = '0;
    logic [W-1:0]  y;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] last_exp = '0;

    always #5 clk = ~clk;

    barrel_shifter #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .k   (k),
        .A_i (a),
        .Y_o (y)
    );

    // Left rotate by arithmetic: low part scaled up modulo 2^W, high part brought down.
    function automatic logic [W-1:0] ref_rotl(input int unsigned v, input int unsigned amt);
        int unsigned r;
        r = ((v << amt) % (1 << W)) + (v >> (W - amt));
        return r[W-1:0];
    endfunction

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge: applies inputs, checks the output has not
    // moved before the edge, then checks the new result 1 unit after the next edge.
    task automatic step(input logic [W-1:0] av, input logic [SW-1:0] kv, input string tag);
        a = av;
        k = kv;
        #2;
        check_eq({tag, " hold"}, y, last_exp);
        @(posedge clk);
        #1;
        last_exp = ref_rotl(int'(av), int'(kv));
        check_eq(tag, y, last_exp);
    endtask

    logic [W-1:0] sweep_exp [W];
    logic [W-1:0] ra;
    logic [SW-1:0] rk;

    initial begin
        sweep_exp = '{8'h25, 8'h4A, 8'h94, 8'h29, 8'h52, 8'hA4, 8'h49, 8'h92};

        // Reset with live inputs present.
        a = 8'h25;
        k = 3'd3;
        #1 rst = 1'b1;
        #1 check_eq("reset immediate", y, 8'h00);
        @(posedge clk); #1 check_eq("reset hold 1", y, 8'h00);
        @(posedge clk); #1 check_eq("reset hold 2", y, 8'h00);
        rst = 1'b0;
        #2 check_eq("post-release pre-edge", y, 8'h00);
        @(posedge clk); #1;
        check_eq("first after reset", y, 8'h29);
        last_exp = 8'h29;

        // Fixed data, k swept; also compared against the literal table.
        for (int i = 0; i < int'(W); i++) begin
            step(8'h25, i[SW-1:0], "sweep");
            check_eq("sweep const", y, sweep_exp[i]);
        end

        step(8'h01, 3'd7, "walk 01 k7");
        check_eq("walk 01 k7 const", y, 8'h80);
        step(8'h80, 3'd1, "wrap 80 k1");
        check_eq("wrap 80 k1 const", y, 8'h01);
        step(8'hFF, 3'd5, "all ones");
        check_eq("all ones const", y, 8'hFF);
        step(8'h00, 3'd6, "all zeros");
        check_eq("all zeros const", y, 8'h00);
        step(8'hA5, 3'd4, "A5 k4");
        check_eq("A5 k4 const", y, 8'h5A);

        // Back-to-back k changes, no bubbles.
        step(8'h3C, 3'd1, "b2b k1");
        check_eq("b2b k1 const", y, 8'h78);
        step(8'h3C, 3'd2, "b2b k2");
        check_eq("b2b k2 const", y, 8'hF0);
        step(8'h3C, 3'd3, "b2b k3");
        check_eq("b2b k3 const", y, 8'hE1);

        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                step(8'hFF, 3'd0, "pre-reset");
                #2 rst = 1'b1;
                #1 check_eq("mid reset immediate", y, 8'h00);
                @(posedge clk); #1 check_eq("mid reset hold", y, 8'h00);
                rst = 1'b0;
                last_exp = 8'h00;
            end
            ra = W'($urandom);
            rk = SW'($urandom_range(W - 1, 0));
            step(ra, rk, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
